// File: rtl/miner_result_uart_tx.sv
// Miner result reporter: snapshots found/exhausted events and sends a
// 39-byte framed report (sync, status, nonce, hash, XOR checksum) over UART 8N1.
module miner_result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         found,
  input  logic         exhausted,
  input  logic [31:0]  nonce_out,
  input  logic [255:0] hash_out,
  output logic         tx,
  output logic         tx_busy,
  output logic [15:0]  frames_sent,
  output logic [7:0]   drop_count
);

  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned SNAP_W    = 296;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned LAST_BYTE = 38;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  state_t              state_q, state_d;
  logic                found_q, exhausted_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [IDX_W-1:0]    byte_q, byte_d;
  logic [7:0]          shreg_q, shreg_d;
  logic [7:0]          csum_q, csum_d;
  logic [SNAP_W-1:0]   snap_q, snap_d;
  logic                tx_d, busy_d;
  logic [15:0]         frames_d;
  logic [7:0]          drop_d;
  logic                ev_found, ev_exh, ev_any, bit_end;

  assign ev_found = found & ~found_q;
  assign ev_exh   = exhausted & ~exhausted_q;
  assign ev_any   = ev_found | ev_exh;
  assign bit_end  = (cnt_q == CNT_LAST);

  // State and datapath registers; tx resets high so an abort idles the line at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
      cnt_q       <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      shreg_q     <= '0;
      csum_q      <= '0;
      snap_q      <= '0;
      tx          <= 1'b1;
      tx_busy     <= 1'b0;
      frames_sent <= '0;
      drop_count  <= '0;
    end else begin
      state_q     <= state_d;
      found_q     <= found;
      exhausted_q <= exhausted;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      shreg_q     <= shreg_d;
      csum_q      <= csum_d;
      snap_q      <= snap_d;
      tx          <= tx_d;
      tx_busy     <= busy_d;
      frames_sent <= frames_d;
      drop_count  <= drop_d;
    end
  end

  // Next-state, bit timing, byte loading and counters.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shreg_d  = shreg_q;
    csum_d   = csum_q;
    snap_d   = snap_q;
    tx_d     = tx;
    busy_d   = tx_busy;
    frames_d = frames_sent;
    drop_d   = drop_count;

    if ((state_q != IDLE) && ev_any && (drop_count != 8'hFF)) begin
      drop_d = drop_count + 8'd1;
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (ev_any) begin
          snap_d  = {(ev_found ? 8'h01 : 8'h02), nonce_out, hash_out};
          shreg_d = SYNC_BYTE;
          csum_d  = '0;
          byte_d  = '0;
          cnt_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (byte_q == IDX_W'(LAST_BYTE)) begin
            state_d = DONE;
          end else begin
            byte_d  = byte_q + IDX_W'(1);
            tx_d    = 1'b0;
            state_d = START;
            // Payload bytes stream out of the snapshot; the last slot carries the checksum.
            if (byte_q == IDX_W'(LAST_BYTE - 1)) begin
              shreg_d = csum_q;
            end else begin
              shreg_d = snap_q[SNAP_W-1 -: 8];
              snap_d  = {snap_q[SNAP_W-9:0], 8'h00};
              csum_d  = csum_q ^ snap_q[SNAP_W-1 -: 8];
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        frames_d = frames_sent + 16'd1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_miner_result_uart_tx.sv
// Self-checking bench for miner_result_uart_tx: decodes the UART line at mid-bit
// and compares every frame against a byte-level reference frame built from the inputs.
module tb_miner_result_uart_tx;

  localparam int unsigned CPB  = 4;
  localparam int unsigned HALF = CPB / 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         found, exhausted;
  logic [31:0]  nonce_out;
  logic [255:0] hash_out;
  logic         tx, tx_busy;
  logic [15:0]  frames_sent;
  logic [7:0]   drop_count;

  int checks = 0;
  int errors = 0;

  miner_result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .found(found), .exhausted(exhausted),
    .nonce_out(nonce_out), .hash_out(hash_out), .tx(tx), .tx_busy(tx_busy),
    .frames_sent(frames_sent), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference frame: sync, status, nonce MSB first, hash MSB first, XOR of bytes 1..37.
  task automatic build_frame(input logic [7:0] st, input logic [31:0] n,
                             input logic [255:0] h, output logic [7:0] f [39]);
    logic [7:0] cs;
    f[0] = 8'hA5;
    f[1] = st;
    for (int i = 0; i < 4; i++)  f[2+i] = n[31-8*i -: 8];
    for (int i = 0; i < 32; i++) f[6+i] = h[255-8*i -: 8];
    cs = 8'h00;
    for (int k = 1; k < 38; k++) cs = cs ^ f[k];
    f[38] = cs;
  endtask

  function automatic logic [255:0] rand_hash();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction

  // mode 0: quiet; 1: three found edges plus a nonce change mid-frame; 2: 300 found edges.
  task automatic run_frame(input string tag, input bit rf, input bit re,
                           input logic [31:0] n, input logic [255:0] h, input int mode,
                           output logic [7:0] got [39]);
    logic [7:0]  exp_f [39];
    logic [15:0] fs0, fs_exp;
    logic        bits [390];
    int          frame_err;
    bit          busy_ok;
    fs0 = frames_sent;
    fs_exp = fs0 + 16'd1;
    @(negedge clk);
    nonce_out = n;
    hash_out  = h;
    if (rf) found = 1'b1;
    if (re) exhausted = 1'b1;
    build_frame(rf ? 8'h01 : 8'h02, n, h, exp_f);
    @(negedge clk);
    check({tag, " start tx"}, tx, 1'b0);
    check({tag, " start busy"}, tx_busy, 1'b1);
    busy_ok = 1'b1;
    fork
      begin
        for (int k = 0; k < 390; k++) begin
          if (k == 0) tick(HALF); else tick(CPB);
          bits[k] = tx;
          if (!tx_busy) busy_ok = 1'b0;
        end
      end
      begin
        if (mode == 1) begin
          tick(100);
          nonce_out = ~n;
          for (int i = 0; i < 3; i++) begin
            found = 1'b0; tick(1);
            found = 1'b1; tick(1);
          end
        end else if (mode == 2) begin
          tick(50);
          for (int i = 0; i < 300; i++) begin
            found = 1'b0; tick(1);
            found = 1'b1; tick(1);
          end
        end
      end
    join
    tick(CPB - HALF);
    check({tag, " done busy"}, tx_busy, 1'b1);
    check({tag, " done tx"}, tx, 1'b1);
    check({tag, " done frames"}, frames_sent, fs0);
    tick(1);
    check({tag, " end busy"}, tx_busy, 1'b0);
    check({tag, " end tx"}, tx, 1'b1);
    check({tag, " end frames"}, frames_sent, fs_exp);
    check({tag, " busy held"}, busy_ok, 1'b1);
    frame_err = 0;
    for (int b = 0; b < 39; b++) begin
      if (bits[10*b] !== 1'b0 || bits[10*b+9] !== 1'b1) frame_err++;
      for (int i = 0; i < 8; i++) got[b][i] = bits[10*b+1+i];
    end
    check({tag, " framing"}, frame_err, 0);
    for (int b = 0; b < 39; b++)
      check($sformatf("%s byte%0d", tag, b), got[b], exp_f[b]);
  endtask

  task automatic lower_levels();
    @(negedge clk);
    found = 1'b0;
    exhausted = 1'b0;
    tick(2);
  endtask

  initial begin
    logic [7:0]  got [39];
    logic [31:0] n;
    logic [255:0] h;
    bit          quiet;
    int          kind;
    logic [15:0] fs_hold;

    rst_n = 1'b0; found = 1'b0; exhausted = 1'b0;
    nonce_out = '0; hash_out = '0;
    tick(3);
    check("reset tx", tx, 1'b1);
    check("reset busy", tx_busy, 1'b0);
    check("reset frames", frames_sent, 16'h0);
    check("reset drops", drop_count, 8'h0);
    rst_n = 1'b1;
    tick(2);

    run_frame("found", 1'b1, 1'b0, 32'h1234_5678, 256'h1, 0, got);
    check("found status", got[1], 8'h01);
    check("found csum", got[38], 8'h08);
    check("found frames", frames_sent, 16'd1);
    lower_levels();

    run_frame("exh", 1'b0, 1'b1, 32'h0010_0000, {256{1'b1}}, 0, got);
    check("exh status", got[1], 8'h02);
    check("exh csum", got[38], 8'h12);
    lower_levels();

    for (int r = 0; r < 4; r++) begin
      kind = $urandom_range(2, 0);
      n = $urandom;
      h = rand_hash();
      run_frame($sformatf("rand%0d", r), kind != 1, kind != 0, n, h, 0, got);
      lower_levels();
    end

    run_frame("both", 1'b1, 1'b1, $urandom, rand_hash(), 0, got);
    check("both status", got[1], 8'h01);
    check("both drops", drop_count, 8'h0);
    fs_hold = frames_sent;
    quiet = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      tick(1);
      if (tx_busy || !tx) quiet = 1'b0;
    end
    check("hold quiet", quiet, 1'b1);
    check("hold frames", frames_sent, fs_hold);
    check("hold drops", drop_count, 8'h0);
    lower_levels();

    n = $urandom;
    run_frame("drop3", 1'b1, 1'b0, n, rand_hash(), 1, got);
    check("drop3 count", drop_count, 8'd3);
    check("drop3 nonce", {got[2], got[3], got[4], got[5]}, n);
    lower_levels();

    run_frame("dropsat", 1'b1, 1'b0, $urandom, rand_hash(), 2, got);
    check("dropsat count", drop_count, 8'hFF);
    lower_levels();

    // Abort in the start bit of byte 10 with reset asserted between clock edges.
    @(negedge clk);
    nonce_out = $urandom;
    hash_out = rand_hash();
    found = 1'b1;
    tick(1 + 100 * CPB + 1);
    check("pre-abort tx", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("abort tx", tx, 1'b1);
    check("abort busy", tx_busy, 1'b0);
    check("abort frames", frames_sent, 16'h0);
    check("abort drops", drop_count, 8'h0);
    @(negedge clk);
    found = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    run_frame("postrst", 1'b1, 1'b0, $urandom, rand_hash(), 0, got);
    check("postrst frames", frames_sent, 16'd1);
    lower_levels();

    @(negedge clk);
    force dut.frames_sent = 16'hFFFF;
    @(negedge clk);
    release dut.frames_sent;
    @(negedge clk);
    check("preload frames", frames_sent, 16'hFFFF);
    run_frame("wrap", 1'b0, 1'b1, $urandom, rand_hash(), 0, got);
    check("wrap frames", frames_sent, 16'h0000);
    lower_levels();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
